reg_file_sb: RTL and testbench

Parametrised successor to the core register file: an N-read / 1-write register file with hardwired-zero x0, write-to-read bypass, asynchronous clear, and a per-register scoreboard of pending writes. The pipeline's issue stage marks destinations pending, writeback clears them, and read ports report busy so the hazard unit can stall. It sits between decode/issue and writeback in the RISC-V core and still exports a0 for the top-level display.

---
 rtl/reg_file_sb_if.sv | 30 +++
 rtl/reg_file_sb.sv | 69 ++++++
 tb/tb_reg_file_sb.sv | 186 ++++++++++++++++++
 3 files changed

// File: rtl/reg_file_sb_if.sv
// Register-file bus: read ports, writeback, issue reservation and status.
// The register file takes the slave view; the pipeline or bench drives the master view.
interface reg_file_sb_if #(
  parameter int A_WIDTH = 5,
  parameter int D_WIDTH = 32,
  parameter int N_READ  = 2
);
  logic [N_READ*A_WIDTH-1:0] ad_r;
  logic [N_READ*D_WIDTH-1:0] rd;
  logic [N_READ-1:0]         busy_r;
  logic                      we;
  logic [A_WIDTH-1:0]        ad_w;
  logic [D_WIDTH-1:0]        wd;
  logic                      iss_valid;
  logic [A_WIDTH-1:0]        iss_ad;
  logic                      iss_ready;
  logic [A_WIDTH:0]          pend_cnt;
  logic                      wb_err;
  logic [D_WIDTH-1:0]        a0;

  modport master (
    output ad_r, we, ad_w, wd, iss_valid, iss_ad,
    input  rd, busy_r, iss_ready, pend_cnt, wb_err, a0
  );

  modport slave (
    input  ad_r, we, ad_w, wd, iss_valid, iss_ad,
    output rd, busy_r, iss_ready, pend_cnt, wb_err, a0
  );
endinterface

// File: rtl/reg_file_sb.sv
// N-read/1-write register file with x0 hardwired, write bypass and pending-write scoreboard.
// Reads/busy/iss_ready are zero-latency; iss_ready low holds off a second reservation until writeback.
module reg_file_sb #(
  parameter int A_WIDTH = 5,
  parameter int D_WIDTH = 32,
  parameter int N_READ  = 2
) (
  input  logic         clk,
  input  logic         rst,
  reg_file_sb_if.slave rf
);
  localparam int R = 1 << A_WIDTH;
  localparam logic [A_WIDTH-1:0] A0_ADDR = A_WIDTH'(10);

  logic [D_WIDTH-1:0] regs_q [R];
  logic [R-1:0]       pending_q, pending_d;
  logic [A_WIDTH:0]   pend_cnt_q, pend_cnt_d;
  logic               wb_err_q, wb_err_d;

  logic wr_hit, wr_en, iss_rdy, iss_acc, cnt_inc, cnt_dec;

  // Bypass is suppressed while reset is held so every read reports zero.
  assign wr_hit = rf.we && !rst;
  assign wr_en  = wr_hit && (rf.ad_w != '0);

  for (genvar i = 0; i < N_READ; i++) begin : g_rd
    logic [A_WIDTH-1:0] a;
    logic               hit;
    assign a   = rf.ad_r[i*A_WIDTH +: A_WIDTH];
    assign hit = wr_hit && (rf.ad_w == a);
    assign rf.rd[i*D_WIDTH +: D_WIDTH] = (a == '0) ? '0 : (hit ? rf.wd : regs_q[a]);
    assign rf.busy_r[i] = pending_q[a] && !hit;
  end

  assign rf.a0 = (wr_hit && rf.ad_w == A0_ADDR) ? rf.wd : regs_q[A0_ADDR];

  assign iss_rdy      = !pending_q[rf.iss_ad] || (rf.we && rf.ad_w == rf.iss_ad);
  assign rf.iss_ready = iss_rdy;
  assign iss_acc      = rf.iss_valid && iss_rdy && (rf.iss_ad != '0) && !rst;

  // A same-register writeback plus re-issue leaves the bit set, so the count holds.
  assign cnt_inc = iss_acc && !pending_q[rf.iss_ad];
  assign cnt_dec = wr_en && pending_q[rf.ad_w] && !(iss_acc && rf.iss_ad == rf.ad_w);

  always_comb begin
    pending_d = pending_q;
    if (wr_en) pending_d[rf.ad_w] = 1'b0;
    if (iss_acc) pending_d[rf.iss_ad] = 1'b1;
    pend_cnt_d = pend_cnt_q + (A_WIDTH+1)'(cnt_inc) - (A_WIDTH+1)'(cnt_dec);
    wb_err_d   = wb_err_q || (wr_en && !pending_q[rf.ad_w]);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < R; i++) regs_q[i] <= '0;
      pending_q  <= '0;
      pend_cnt_q <= '0;
      wb_err_q   <= 1'b0;
    end else begin
      if (wr_en) regs_q[rf.ad_w] <= rf.wd;
      pending_q  <= pending_d;
      pend_cnt_q <= pend_cnt_d;
      wb_err_q   <= wb_err_d;
    end
  end

  assign rf.pend_cnt = pend_cnt_q;
  assign rf.wb_err   = wb_err_q;
endmodule

// File: tb/tb_reg_file_sb.sv
// Scoreboard bench for reg_file_sb: directed hazard cases followed by randomized traffic.
module tb_reg_file_sb;
  localparam int AW = 5;
  localparam int DW = 32;
  localparam int NR = 2;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  reg_file_sb_if #(.A_WIDTH(AW), .D_WIDTH(DW), .N_READ(NR)) bus ();
  reg_file_sb #(.A_WIDTH(AW), .D_WIDTH(DW), .N_READ(NR)) dut (
    .clk (clk),
    .rst (rst),
    .rf  (bus)
  );

  typedef struct packed {
    logic [NR*DW-1:0] rd;
    logic [NR-1:0]    busy;
    logic             iss_ready;
    logic [AW:0]      cnt;
    logic             err;
    logic [DW-1:0]    a0;
  } exp_t;

  exp_t exp_q[$];

  // Reference state: architectural registers, pending set and sticky error.
  logic [DW-1:0] m_mem  [32];
  bit            m_pend [32];
  bit            m_err;

  int n_vec = 0;
  int n_bad = 0;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] want);
    n_vec++;
    if (act !== want) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, want, $time);
    end
  endtask

  function automatic int model_cnt();
    int c = 0;
    for (int i = 0; i < 32; i++) c += int'(m_pend[i]);
    return c;
  endfunction

  function automatic logic [DW-1:0] model_read(input logic [AW-1:0] a, input logic r, input logic we,
                                               input logic [AW-1:0] aw, input logic [DW-1:0] wd);
    if (a == 0) return '0;
    if (!r && we && aw == a) return wd;
    return m_mem[a];
  endfunction

  task automatic model_clear();
    for (int i = 0; i < 32; i++) begin
      m_mem[i]  = '0;
      m_pend[i] = 1'b0;
    end
    m_err = 1'b0;
  endtask

  task automatic step(input logic r, input logic we, input logic [AW-1:0] aw, input logic [DW-1:0] wd,
                      input logic iv, input logic [AW-1:0] ia, input logic [AW-1:0] r0, input logic [AW-1:0] r1);
    exp_t          e;
    logic          rdy;
    logic [AW-1:0] ra [NR];
    @(posedge clk);
    #1;
    rst           = r;
    bus.we        = we;
    bus.ad_w      = aw;
    bus.wd        = wd;
    bus.iss_valid = iv;
    bus.iss_ad    = ia;
    bus.ad_r      = {r1, r0};
    if (r) model_clear();
    ra[0] = r0;
    ra[1] = r1;
    for (int i = 0; i < NR; i++) begin
      e.rd[i*DW +: DW] = model_read(ra[i], r, we, aw, wd);
      e.busy[i]        = m_pend[ra[i]] && !(we && aw == ra[i]);
    end
    rdy         = !m_pend[ia] || (we && aw == ia);
    e.iss_ready = rdy;
    e.cnt       = (AW+1)'(model_cnt());
    e.err       = m_err;
    e.a0        = model_read(AW'(10), r, we, aw, wd);
    exp_q.push_back(e);
    if (!r) begin
      if (we && aw != 0) begin
        if (!m_pend[aw]) m_err = 1'b1;
        m_mem[aw]  = wd;
        m_pend[aw] = 1'b0;
      end
      if (iv && rdy && ia != 0) m_pend[ia] = 1'b1;
    end
  endtask

  task automatic rd2(input logic [AW-1:0] r0, input logic [AW-1:0] r1);
    step(1'b0, 1'b0, '0, '0, 1'b0, '0, r0, r1);
  endtask

  function automatic logic [AW-1:0] pick();
    if ($urandom_range(0, 3) == 0) return AW'($urandom_range(0, 31));
    return AW'($urandom_range(0, 11));
  endfunction

  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge clk);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        check("rd",        bus.rd,        e.rd);
        check("busy_r",    bus.busy_r,    e.busy);
        check("iss_ready", bus.iss_ready, e.iss_ready);
        check("pend_cnt",  bus.pend_cnt,  e.cnt);
        check("wb_err",    bus.wb_err,    e.err);
        check("a0",        bus.a0,        e.a0);
      end
    end
  end

  initial begin : driver
    int wait_cyc;
    bus.we = 1'b0; bus.ad_w = '0; bus.wd = '0;
    bus.iss_valid = 1'b0; bus.iss_ad = '0; bus.ad_r = '0;
    model_clear();

    step(1'b1, 1'b1, AW'(4), 32'h1111_2222, 1'b1, AW'(4), AW'(4), AW'(10));
    step(1'b1, 1'b0, '0, '0, 1'b0, '0, '0, '0);
    for (int a = 0; a < 32; a++) rd2(AW'(a), AW'(31 - a));

    step(1'b0, 1'b1, AW'(0), 32'hDEAD_BEEF, 1'b0, '0, AW'(0), AW'(0));
    rd2(AW'(0), AW'(0));

    step(1'b0, 1'b1, AW'(5), 32'h1234_5678, 1'b0, '0, AW'(5), AW'(1));
    rd2(AW'(5), AW'(5));
    step(1'b0, 1'b1, AW'(10), 32'h0000_00A5, 1'b0, '0, AW'(10), AW'(5));
    rd2(AW'(10), AW'(0));

    step(1'b0, 1'b0, '0, '0, 1'b1, AW'(7), AW'(7), AW'(0));
    step(1'b0, 1'b0, '0, '0, 1'b0, AW'(7), AW'(7), AW'(7));
    step(1'b0, 1'b1, AW'(7), 32'h42, 1'b0, AW'(7), AW'(7), AW'(5));
    rd2(AW'(7), AW'(0));

    step(1'b0, 1'b0, '0, '0, 1'b1, AW'(7), AW'(7), AW'(0));
    step(1'b0, 1'b1, AW'(7), 32'h42, 1'b1, AW'(7), AW'(7), AW'(3));
    step(1'b0, 1'b0, '0, '0, 1'b0, AW'(7), AW'(7), AW'(0));
    step(1'b0, 1'b1, AW'(7), 32'h77, 1'b0, '0, AW'(7), AW'(7));

    step(1'b0, 1'b1, AW'(3), 32'h3333, 1'b0, '0, AW'(3), AW'(0));
    step(1'b0, 1'b0, '0, '0, 1'b1, AW'(9), AW'(3), AW'(9));
    step(1'b0, 1'b1, AW'(9), 32'h9999, 1'b0, '0, AW'(9), AW'(3));
    rd2(AW'(9), AW'(3));

    for (int a = 1; a <= 20; a++) step(1'b0, 1'b0, '0, '0, 1'b1, AW'(a), AW'(a), AW'(a - 1));
    step(1'b1, 1'b1, AW'(5), 32'hCAFE_F00D, 1'b1, AW'(21), AW'(5), AW'(10));
    step(1'b0, 1'b0, '0, '0, 1'b0, '0, AW'(1), AW'(7));
    for (int a = 0; a < 32; a++) rd2(AW'(a), AW'(a));

    for (int k = 0; k < 3000; k++) begin
      step(($urandom_range(0, 299) == 0), 1'($urandom_range(0, 1)), pick(), $urandom,
           1'($urandom_range(0, 1)), pick(), pick(), pick());
    end
    rd2('0, '0);

    wait_cyc = 0;
    while (exp_q.size() > 0 && wait_cyc < 10) begin
      @(posedge clk);
      wait_cyc++;
    end
    @(posedge clk);
    if (exp_q.size() > 0) begin
      n_vec++;
      n_bad++;
      $display("FAIL drain: %0d expectations left, required 0", exp_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule
